// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register-file widths, constants and types
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational register-file read port
// Forces r0 to zero; forwards the in-flight write when WRITE_BYPASS_EN is defined.
module regfile_read_port
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dir,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

`ifdef WRITE_BYPASS_EN
  always_comb begin
    data = '0;
    if (dir != REG_ZERO) begin
      data = regs[dir];
      if (wr_en && (wr_dir == dir)) data = wr_data;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_dir, wr_data};

  always_comb begin
    data = '0;
    if (dir != REG_ZERO) data = regs[dir];
  end
`endif

endmodule

// File: rtl/register_file_wb.sv
// rtl/register_file_wb.sv - 32x32 MIPS register file with write-back port and status
// Optional same-cycle write forwarding: define WRITE_BYPASS_EN.
module register_file_wb
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dir_a,
  input  logic [ADDR_W-1:0] dir_b,
  input  logic [ADDR_W-1:0] dir_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              reg_write,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] dbg_dir,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] last_dir_w,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              accept;

  // Writes to r0 are dropped entirely: no storage, no ack, no count.
  assign accept = reg_write && (dir_w != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_ack     <= 1'b0;
      last_dir_w <= '0;
      wr_count   <= '0;
    end else begin
      wr_ack <= accept;
      if (accept) begin
        regs[dir_w] <= data_w;
        last_dir_w  <= dir_w;
        wr_count    <= wr_count + 16'd1;
      end
    end
  end

  regfile_read_port u_port_a (
    .dir     (dir_a),
    .regs    (regs),
    .wr_en   (accept),
    .wr_dir  (dir_w),
    .wr_data (data_w),
    .data    (data_a)
  );

  regfile_read_port u_port_b (
    .dir     (dir_b),
    .regs    (regs),
    .wr_en   (accept),
    .wr_dir  (dir_w),
    .wr_data (data_w),
    .data    (data_b)
  );

  regfile_read_port u_port_dbg (
    .dir     (dbg_dir),
    .regs    (regs),
    .wr_en   (accept),
    .wr_dir  (dir_w),
    .wr_data (data_w),
    .data    (dbg_data)
  );

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
32 x 32-bit MIPS general-purpose register file with its write-back port. It sits directly downstream of the write-destination mux: the mux picks rt or rd, and that choice drives dir_w here.
- Provides two combinational read ports for the decode/ALU stage.
- Provides one synchronous write port.
- Provides a debug read port and write-acknowledge status for the bench and top-level observation.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers (2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
dir_a  input  ADDR_W  read port A address (rs)
dir_b  input  ADDR_W  read port B address (rt)
dir_w  input  ADDR_W  write address, driven by the destination mux output
data_w  input  DATA_W  write-back data
reg_write  input  1  write enable from control
data_a  output  DATA_W  contents of register dir_a
data_b  output  DATA_W  contents of register dir_b
dbg_dir  input  ADDR_W  debug read address
dbg_data  output  DATA_W  contents of register dbg_dir
wr_ack  output  1  registered pulse, one cycle after an accepted write
last_dir_w  output  ADDR_W  address of the most recent accepted write
wr_count  output  16  number of accepted writes since reset, wraps

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-high (reset). The reset assertion clears state immediately, independent of clk.
- Reset state:
  - all NUM_REGS registers = 0
  - wr_ack = 0, last_dir_w = 0, wr_count = 0
  - data_a, data_b and dbg_data therefore read 0.
- Register 0 is hardwired to zero:
  - reads of address 0 always return 0;
  - writes to address 0 are discarded, do not assert wr_ack, and do not count.
- Accepted write: reg_write=1 and dir_w!=0 at a rising clk edge.
  - regs[dir_w] <= data_w
  - wr_ack <= 1
  - last_dir_w <= dir_w
  - wr_count <= wr_count+1 (modulo 2^16, 0xFFFF -> 0x0000)
- Any other cycle: wr_ack <= 0; last_dir_w and wr_count hold.
- Reads are purely combinational from the array; read latency is 0 cycles.
- Written data is visible on read ports from the cycle after the write edge (unless the bypass below is compiled in).
- Simultaneous read and write of the same address in one cycle: ports return the old value (bypass off).
- Both read ports and the debug port may address the same register simultaneously; no conflict.
- X or unknown dir_w with reg_write=0 has no effect.
- Reset asserted mid-operation overrides any write in the same cycle: no write occurs, and all state clears.
- No handshake or stall. The write is fire-and-forget; the upstream stage holds nothing.

Optional Feature:
Macro WRITE_BYPASS_EN.
- Defined: when reg_write=1, dir_w!=0 and dir_w equals dir_a, dir_b or dbg_dir, that port returns data_w combinationally in the same cycle (write-through forwarding).
- Not defined: ports return array contents only (old value during the write cycle).
- Zero-register rule holds in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0
  - typedefs reg_addr_t (ADDR_W bits) and word_t (DATA_W bits)
- One natural sub-module, regfile_read_port: one address in, one word out; applies the zero-register rule and optional bypass. Instantiated three times (A, B, debug).
- Array, write logic and status counters stay in the top module.

Test Plan:
- Reset: assert reset async mid-cycle after writing 0xDEADBEEF to r5 -> data_a(dir_a=5)=0 immediately; wr_count=0; wr_ack=0; last_dir_w=0.
- Basic write/read: reg_write=1, dir_w=8, data_w=0x12345678 for one edge -> next cycle data_a(dir_a=8)=0x12345678, wr_ack=1 for exactly one cycle, last_dir_w=8, wr_count=1.
- Zero register: reg_write=1, dir_w=0, data_w=0xFFFFFFFF -> data_b(dir_b=0)=0; wr_ack stays 0; wr_count unchanged.
- Same-cycle read/write: r3=0x11; write dir_w=3, data_w=0x22 with dir_a=3 -> during write cycle data_a=0x11 (bypass off) or 0x22 (WRITE_BYPASS_EN); after edge data_a=0x22 in both builds.
- Dual read plus debug: r1=0xA, r2=0xB -> dir_a=1, dir_b=2, dbg_dir=2 -> data_a=0xA, data_b=0xB, dbg_data=0xB in the same cycle.
- Counter wrap: perform 65536 accepted writes to r31 -> wr_count returns to 0x0000; r31 holds the last data_w.
